// File: rtl/mem_arbiter.sv
// Two-port RAM arbiter: the CPU has fixed priority, and a starvation counter forces a
// device grant after MAX_WAIT consecutive lost arbitrations. Each grant runs through
// IDLE -> ACCESS (RAM_LAT cycles) -> ACK.
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RAM_LAT  = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dev_req,
  input  logic              dev_we,
  input  logic [ADDR_W-1:0] dev_addr,
  input  logic [DATA_W-1:0] dev_wdata,
  output logic              dev_ack,
  output logic [DATA_W-1:0] dev_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              owner
);

  localparam logic [1:0] LatLast = 2'(RAM_LAT - 1);
  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  typedef enum logic [1:0] {StIdle, StAccess, StAck} state_e;

  state_e              state_q, state_d;
  logic [1:0]          lat_cnt_q, lat_cnt_d;
  logic [3:0]          wait_cnt_q, wait_cnt_d;
  logic                txn_we_q, txn_we_d;
  logic                ram_en_q, ram_en_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dev_rdata_q, dev_rdata_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                dev_ack_q, dev_ack_d;
  logic                owner_q, owner_d;
  logic                dev_wins;

  // Arbitration, sequencing and datapath next-state.
  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    txn_we_d    = txn_we_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dev_rdata_d = dev_rdata_q;
    cpu_ack_d   = 1'b0;
    dev_ack_d   = 1'b0;
    owner_d     = owner_q;
    dev_wins    = dev_req && (!cpu_req || (wait_cnt_q >= MaxWait));

    unique case (state_q)
      StIdle: begin
        if (dev_wins) begin
          state_d     = StAccess;
          lat_cnt_d   = 2'd0;
          wait_cnt_d  = 4'd0;
          owner_d     = 1'b1;
          txn_we_d    = dev_we;
          ram_en_d    = 1'b1;
          ram_we_d    = dev_we;
          ram_addr_d  = dev_addr;
          ram_wdata_d = dev_wdata;
        end else if (cpu_req) begin
          state_d     = StAccess;
          lat_cnt_d   = 2'd0;
          owner_d     = 1'b0;
          txn_we_d    = cpu_we;
          ram_en_d    = 1'b1;
          ram_we_d    = cpu_we;
          ram_addr_d  = cpu_addr;
          ram_wdata_d = cpu_wdata;
          // Device lost this round: count towards its starvation limit.
          if (dev_req && (wait_cnt_q < MaxWait)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end
        if (!dev_req) begin
          wait_cnt_d = 4'd0;
        end
      end
      StAccess: begin
        if (lat_cnt_q == LatLast) begin
          state_d = StAck;
          if (!txn_we_q) begin
            if (owner_q) dev_rdata_d = ram_rdata;
            else         cpu_rdata_d = ram_rdata;
          end
          cpu_ack_d = !owner_q;
          dev_ack_d = owner_q;
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      lat_cnt_q   <= 2'd0;
      wait_cnt_q  <= 4'd0;
      txn_we_q    <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dev_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dev_ack_q   <= 1'b0;
      owner_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      txn_we_q    <= txn_we_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dev_rdata_q <= dev_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dev_ack_q   <= dev_ack_d;
      owner_q     <= owner_d;
    end
  end

  // All outputs come straight from registers.
  always_comb begin
    cpu_ack   = cpu_ack_q;
    cpu_rdata = cpu_rdata_q;
    dev_ack   = dev_ack_q;
    dev_rdata = dev_rdata_q;
    ram_en    = ram_en_q;
    ram_we    = ram_we_q;
    ram_addr  = ram_addr_q;
    ram_wdata = ram_wdata_q;
    busy      = (state_q != StIdle);
    owner     = owner_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 has RAM_LAT=1 and carries the directed tests;
// instances 1..3 (RAM_LAT=2..4) cover the latency sweep. Each instance has its own RAM model.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cpu_req_v, dev_req_v;
  logic       cpu_we, dev_we;
  logic [7:0] cpu_addr, dev_addr, cpu_wdata, dev_wdata;

  logic       cpu_ack_v [4];
  logic       dev_ack_v [4];
  logic       ram_en_v  [4];
  logic       ram_we_v  [4];
  logic       busy_v    [4];
  logic       owner_v   [4];
  logic [7:0] cpu_rdata_v [4];
  logic [7:0] dev_rdata_v [4];
  logic [7:0] ram_addr_v  [4];
  logic [7:0] ram_wdata_v [4];
  logic [7:0] ram_rdata_v [4];

  logic [7:0] mem [4][256];
  int         rd_age [4];
  int         en_cnt [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    mem_arbiter #(
      .ADDR_W  (8),
      .DATA_W  (8),
      .RAM_LAT (k + 1),
      .MAX_WAIT(4)
    ) u_dut (
      .clk      (clk),
      .reset    (rst_n),
      .cpu_req  (cpu_req_v[k]),
      .cpu_we   (cpu_we),
      .cpu_addr (cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_ack  (cpu_ack_v[k]),
      .cpu_rdata(cpu_rdata_v[k]),
      .dev_req  (dev_req_v[k]),
      .dev_we   (dev_we),
      .dev_addr (dev_addr),
      .dev_wdata(dev_wdata),
      .dev_ack  (dev_ack_v[k]),
      .dev_rdata(dev_rdata_v[k]),
      .ram_en   (ram_en_v[k]),
      .ram_we   (ram_we_v[k]),
      .ram_addr (ram_addr_v[k]),
      .ram_wdata(ram_wdata_v[k]),
      .ram_rdata(ram_rdata_v[k]),
      .busy     (busy_v[k]),
      .owner    (owner_v[k])
    );
  end

  // RAM models: contents are addr ^ 0xB5 after reset; read data is only valid
  // RAM_LAT-1 cycles after the ram_en cycle, junk (0xEE) otherwise.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst_n) begin
        for (int a = 0; a < 256; a++) mem[k][a] <= 8'(a) ^ 8'hB5;
        rd_age[k] <= 0;
      end else begin
        if (ram_en_v[k] && ram_we_v[k]) mem[k][ram_addr_v[k]] <= ram_wdata_v[k];
        if (ram_en_v[k]) rd_age[k] <= 1;
        else if (rd_age[k] != 0 && rd_age[k] < 7) rd_age[k] <= rd_age[k] + 1;
      end
      if (ram_en_v[k]) en_cnt[k] <= en_cnt[k] + 1;
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      ram_rdata_v[k] = 8'hEE;
      if ((k == 0 && ram_en_v[k]) || (k > 0 && rd_age[k] == k)) begin
        ram_rdata_v[k] = mem[k][ram_addr_v[k]];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on instance k; returns read data, cycles from the
  // sampling edge to the ack cycle, and ram_en cycles seen.
  task automatic do_txn(input int k, input logic is_dev, input logic we, input logic [7:0] addr,
                        input logic [7:0] wdata, output logic [7:0] rdata, output int cycles,
                        output int pulses);
    int   en0;
    logic got;
    en0 = en_cnt[k];
    got = 1'b0;
    cycles = 0;
    if (is_dev) begin
      dev_we = we; dev_addr = addr; dev_wdata = wdata; dev_req_v[k] = 1'b1;
    end else begin
      cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req_v[k] = 1'b1;
    end
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      cycles++;
      got = is_dev ? dev_ack_v[k] : cpu_ack_v[k];
    end
    check_eq("txn_ack_seen", got, 1'b1);
    rdata = is_dev ? dev_rdata_v[k] : cpu_rdata_v[k];
    cpu_req_v[k] = 1'b0;
    dev_req_v[k] = 1'b0;
    tick();
    pulses = en_cnt[k] - en0;
  endtask

  logic [7:0] rd;
  int         cyc, pul, ng;
  logic [9:0] starve_exp;

  initial begin
    rst_n = 1'b0;
    cpu_req_v = '0; dev_req_v = '0;
    cpu_we = 1'b0; dev_we = 1'b0;
    cpu_addr = '0; dev_addr = '0; cpu_wdata = '0; dev_wdata = '0;
    for (int k = 0; k < 4; k++) en_cnt[k] = 0;
    tick(); tick();
    check_eq("rst_busy", busy_v[0], 1'b0);
    check_eq("rst_ram_en", ram_en_v[0], 1'b0);
    check_eq("rst_owner", owner_v[0], 1'b0);
    rst_n = 1'b1;
    tick();

    // CPU read of 0x10 with RAM_LAT=1.
    cpu_req_v[0] = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    tick();
    check_eq("rd_c1_ram_en", ram_en_v[0], 1'b1);
    check_eq("rd_c1_ram_we", ram_we_v[0], 1'b0);
    check_eq("rd_c1_addr", ram_addr_v[0], 8'h10);
    check_eq("rd_c1_busy", busy_v[0], 1'b1);
    check_eq("rd_c1_ack", cpu_ack_v[0], 1'b0);
    tick();
    check_eq("rd_c2_ack", cpu_ack_v[0], 1'b1);
    check_eq("rd_c2_rdata", cpu_rdata_v[0], 8'hA5);
    check_eq("rd_c2_ram_en", ram_en_v[0], 1'b0);
    check_eq("rd_c2_busy", busy_v[0], 1'b1);
    check_eq("rd_c2_dev_ack", dev_ack_v[0], 1'b0);
    cpu_req_v[0] = 1'b0;
    tick();
    check_eq("rd_c3_ack", cpu_ack_v[0], 1'b0);
    check_eq("rd_c3_busy", busy_v[0], 1'b0);

    // Device read to give dev_rdata a known non-zero value.
    do_txn(0, 1'b1, 1'b0, 8'h20, 8'h00, rd, cyc, pul);
    check_eq("dev_rd_data", rd, 8'h95);

    // Device write 0x5C to 0x3F.
    dev_req_v[0] = 1'b1; dev_we = 1'b1; dev_addr = 8'h3F; dev_wdata = 8'h5C;
    pul = en_cnt[0];
    tick();
    check_eq("wr_ram_en", ram_en_v[0], 1'b1);
    check_eq("wr_ram_we", ram_we_v[0], 1'b1);
    check_eq("wr_addr", ram_addr_v[0], 8'h3F);
    check_eq("wr_wdata", ram_wdata_v[0], 8'h5C);
    check_eq("wr_owner", owner_v[0], 1'b1);
    tick();
    check_eq("wr_dev_ack", dev_ack_v[0], 1'b1);
    check_eq("wr_cpu_ack", cpu_ack_v[0], 1'b0);
    check_eq("wr_ram_we_off", ram_we_v[0], 1'b0);
    check_eq("wr_dev_rdata_kept", dev_rdata_v[0], 8'h95);
    check_eq("wr_wdata_held", ram_wdata_v[0], 8'h5C);
    dev_req_v[0] = 1'b0;
    tick();
    check_eq("wr_ack_once", dev_ack_v[0], 1'b0);
    check_eq("wr_en_pulses", en_cnt[0] - pul, 1);
    check_eq("wr_owner_held", owner_v[0], 1'b1);
    do_txn(0, 1'b0, 1'b0, 8'h3F, 8'h00, rd, cyc, pul);
    check_eq("wr_readback", rd, 8'h5C);

    // Simultaneous first request: CPU first, then device.
    cpu_we = 1'b0; dev_we = 1'b0; cpu_addr = 8'h01; dev_addr = 8'h02;
    cpu_req_v[0] = 1'b1; dev_req_v[0] = 1'b1;
    tick();
    check_eq("sim_owner_cpu", owner_v[0], 1'b0);
    check_eq("sim_addr_cpu", ram_addr_v[0], 8'h01);
    tick();
    check_eq("sim_cpu_ack", cpu_ack_v[0], 1'b1);
    check_eq("sim_cpu_rdata", cpu_rdata_v[0], 8'hB4);
    check_eq("sim_no_dev_ack", dev_ack_v[0], 1'b0);
    cpu_req_v[0] = 1'b0;
    tick();
    check_eq("sim_idle", busy_v[0], 1'b0);
    tick();
    check_eq("sim_owner_dev", owner_v[0], 1'b1);
    check_eq("sim_addr_dev", ram_addr_v[0], 8'h02);
    tick();
    check_eq("sim_dev_ack", dev_ack_v[0], 1'b1);
    check_eq("sim_dev_rdata", dev_rdata_v[0], 8'hB7);
    dev_req_v[0] = 1'b0;
    tick();

    // Starvation: both held high; every fifth grant goes to the device.
    starve_exp = 10'b10000_10000;
    ng = 0;
    cpu_req_v[0] = 1'b1; dev_req_v[0] = 1'b1;
    for (int c = 0; c < 100 && ng < 10; c++) begin
      tick();
      if (ram_en_v[0]) begin
        check_eq($sformatf("starve_grant_%0d", ng), owner_v[0], starve_exp[ng]);
        ng++;
      end
    end
    check_eq("starve_grants", ng, 10);
    cpu_req_v[0] = 1'b0; dev_req_v[0] = 1'b0;
    for (int c = 0; c < 10 && busy_v[0]; c++) tick();
    check_eq("starve_idle", busy_v[0], 1'b0);

    // Reset mid-ACCESS of a CPU read, with the request still held.
    cpu_req_v[0] = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    tick();
    check_eq("rm_pre_en", ram_en_v[0], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rm_ram_en", ram_en_v[0], 1'b0);
    check_eq("rm_ram_addr", ram_addr_v[0], 8'h00);
    check_eq("rm_busy", busy_v[0], 1'b0);
    check_eq("rm_cpu_rdata", cpu_rdata_v[0], 8'h00);
    check_eq("rm_dev_rdata", dev_rdata_v[0], 8'h00);
    check_eq("rm_acks", {cpu_ack_v[0], dev_ack_v[0]}, 2'b00);
    check_eq("rm_owner", owner_v[0], 1'b0);
    tick();
    rst_n = 1'b1;
    check_eq("rm_rel_ack", cpu_ack_v[0], 1'b0);
    check_eq("rm_rel_busy", busy_v[0], 1'b0);
    tick();
    check_eq("rm_regrant_en", ram_en_v[0], 1'b1);
    check_eq("rm_regrant_busy", busy_v[0], 1'b1);
    tick();
    check_eq("rm_ack", cpu_ack_v[0], 1'b1);
    check_eq("rm_rdata", cpu_rdata_v[0], 8'hA5);
    cpu_req_v[0] = 1'b0;
    tick();

    // Latency sweep, RAM_LAT = k+1.
    for (int k = 0; k < 4; k++) begin
      do_txn(k, 1'b0, 1'b0, 8'h10 + 8'(k), 8'h00, rd, cyc, pul);
      check_eq($sformatf("lat%0d_cycles", k + 1), cyc, k + 2);
      check_eq($sformatf("lat%0d_en_pulses", k + 1), pul, 1);
      check_eq($sformatf("lat%0d_rdata", k + 1), rd, (8'h10 + 8'(k)) ^ 8'hB5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
